// File: rtl/clk_div_int_if.sv
// Configuration/output bundle of the integer clock divider.
// The register file drives ratio and enable; slow-domain logic takes the
// divided clock and its period strobe.
interface clk_div_int_if #(
    parameter int RATIO_WD = 8
);
    logic                clk_en;
    logic [RATIO_WD-1:0] div_ratio;
    logic                div_clk;
    logic                div_tick;

    // Configuration side: owns ratio/enable, consumes the divided clock.
    modport master (
        output clk_en,
        output div_ratio,
        input  div_clk,
        input  div_tick
    );

    // Divider side.
    modport slave (
        input  clk_en,
        input  div_ratio,
        output div_clk,
        output div_tick
    );
endinterface

// File: rtl/clk_div_int.sv
// Integer clock divider with bypass.
// Divided mode: DIV_CLK/DIV_TICK come straight from flops, H=floor(N/2) high
// cycles then L=N-H low cycles; the ratio is shadowed at each period start so
// a ratio change never produces a runt pulse. Bypass (disabled, or N<2): CLK
// passes through a single mux and the tick is held high; the state machine is
// held in its fresh state so re-enabling starts a clean period.
module clk_div_int #(
    parameter int RATIO_WD = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    clk_div_int_if.slave bus
);

    typedef enum logic [1:0] {
        ST_FRESH,   // reset/bypass state; behaves as the last low cycle
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t              state_q;
    logic [RATIO_WD-1:0] cnt_q;
    logic [RATIO_WD-1:0] ns_q;
    logic                div_q;
    logic                tick_q;

    logic                active;
    logic [RATIO_WD-1:0] high_len;
    logic [RATIO_WD-1:0] low_len;
    logic                high_last;
    logic                low_last;

    // Live enable decode; a change here switches the output mux immediately.
    assign active    = bus.clk_en && (bus.div_ratio >= RATIO_WD'(2));

    // Phase lengths from the shadowed ratio (odd N spends the extra cycle low).
    assign high_len  = ns_q >> 1;
    assign low_len   = ns_q - high_len;
    assign high_last = (cnt_q == high_len - RATIO_WD'(1));
    assign low_last  = (cnt_q == low_len - RATIO_WD'(1));

    // Phase state machine; every output-facing bit is registered.
    always_ff @(posedge clk_i) begin
        if (rst_i || !active) begin
            state_q <= ST_FRESH;
            cnt_q   <= '0;
            ns_q    <= '0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_HIGH: begin
                    tick_q <= 1'b0;
                    if (high_last) begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                        div_q   <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + RATIO_WD'(1);
                    end
                end
                ST_LOW: begin
                    if (low_last) begin
                        // Period boundary: capture the new ratio and rise.
                        state_q <= ST_HIGH;
                        ns_q    <= bus.div_ratio;
                        cnt_q   <= '0;
                        div_q   <= 1'b1;
                        tick_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + RATIO_WD'(1);
                        tick_q  <= 1'b0;
                    end
                end
                default: begin
                    // Fresh start: first active edge opens a period at once.
                    state_q <= ST_HIGH;
                    ns_q    <= bus.div_ratio;
                    cnt_q   <= '0;
                    div_q   <= 1'b1;
                    tick_q  <= 1'b1;
                end
            endcase
        end
    end

    // Output mux: the only combinational path to an output is CLK in bypass.
    assign bus.div_clk  = active ? div_q  : clk_i;
    assign bus.div_tick = active ? tick_q : 1'b1;

endmodule

// File: doc/clk_div_int.md
Name: clk_div_int

Overview:
- Integer clock divider directly downstream of the reset synchronizer in the reference clock domain.
- The synchronizer's active-low SYNC_RST is inverted at integration and drives this block's RST.
- Produces the divided clock (DIV_CLK) and a one-cycle period strobe (DIV_TICK) for slow-domain logic, e.g. the UART bit-clock domain.
- Ratio and enable come from the configuration register file.

Parameters:
RATIO_WD, 8, width of DIV_RATIO and of the internal ratio/phase counters.

Ports:
CLK  input  1  reference clock; all state updates on its rising edge.
RST  input  1  reset, synchronous, active-high; sampled on the CLK rising edge.
CLK_EN  input  1  1 = divide; 0 = bypass.
DIV_RATIO  input  RATIO_WD  division ratio N; 0 and 1 mean bypass.
DIV_CLK  output  1  divided clock (bypass: equals CLK).
DIV_TICK  output  1  one-CLK-cycle strobe marking the start of each DIV_CLK period.

Behaviour:
- Definitions:
  - active = CLK_EN & (DIV_RATIO >= 2), evaluated live.
  - bypass = !active.
- Bypass datapath:
  - DIV_CLK = CLK through a single combinational mux. This is the only combinational path to an output.
  - DIV_TICK = 1 in bypass (every CLK cycle is a period).
- Divided datapath: DIV_CLK and DIV_TICK come straight from flops; no decode logic on the outputs.
- Internal state:
  - div_reg, the DIV_CLK flop.
  - phase counter cnt[RATIO_WD-1:0].
  - shadow ratio n_s[RATIO_WD-1:0].
  - phase bit (HIGH/LOW).
  - tick_reg.
- Phase lengths from the shadow ratio:
  - H = floor(n_s/2) cycles high.
  - L = n_s - H cycles low.
  - Even N gives 50% duty. Odd N is low one cycle longer (N=5: 2 high, 3 low).
- Reset state (RST=1 at a rising edge):
  - div_reg=0, tick_reg=0, cnt=0, n_s=0.
  - phase = LOW-terminal, i.e. the last cycle of a low phase.
  - In reset with active=1: DIV_CLK=0 and DIV_TICK=0.
  - In reset with bypass: outputs follow the bypass rules, so downstream resets still see clocks.
- Operation, each rising edge with RST=0 and active=1:
  - If in LOW-terminal (cnt == L-1, or reset/fresh state):
    - n_s <= DIV_RATIO.
    - div_reg <= 1, tick_reg <= 1, cnt <= 0.
    - phase <= HIGH (or LOW if the new H would be 0 — never, since N>=2).
  - In HIGH with cnt == H-1: div_reg <= 0, cnt <= 0, phase <= LOW, tick_reg <= 0.
  - Otherwise: cnt <= cnt + 1, tick_reg <= 0.
- Timing:
  - First rising DIV_CLK occurs at the first active edge after reset release; latency is 0 edges after release.
  - Period = n_s CLK cycles.
- Ratio change while active (both old and new >= 2):
  - The current period completes with the old ratio.
  - The new ratio is captured at the next period boundary, i.e. the edge that raises DIV_CLK.
  - No short or runt pulses.
- Changes into or out of bypass (CLK_EN or DIV_RATIO crossing 2):
  - Take effect immediately (live mux).
  - Software changes these only while downstream logic tolerates a glitch.
- Leaving bypass: while bypass, state is forced to the reset state every edge. Re-enabling therefore always starts a fresh period: DIV_CLK=1 at the first active edge.
- Counter rules:
  - cnt never exceeds max(H,L)-1.
  - N = 2^RATIO_WD - 1 is legal: H=127, L=128 for RATIO_WD=8.
  - No wrap-around of cnt.
- Simultaneous events:
  - RST has priority over everything.
  - Bypass has priority over a ratio capture.
  - A ratio change on the boundary edge itself is captured on that edge.

Test Plan:
1. CLK period 10 ns, CLK_EN=1, N=4, RST=1 for 3 edges then 0 -> DIV_CLK=0 during reset. After release: 2 cycles high, 2 low, 40 ns period. DIV_TICK high 1 cycle aligned with each DIV_CLK rise.
2. N=5 -> repeating 2 high / 3 low, period 50 ns. N=255 -> 127 high / 128 low. N=2 -> 1/1.
3. N=0, N=1, and separately CLK_EN=0 with N=6 -> DIV_CLK identical to CLK, DIV_TICK constantly 1, including while RST=1.
4. N=4 running; DIV_RATIO set to 6 in the second cycle of a high phase -> that period finishes as 2/2, then 3 high / 3 low. Repeat with the change on the boundary edge -> captured immediately.
5. RST pulsed high for 1 edge in the middle of a high phase, N=6 -> DIV_CLK=0 and DIV_TICK=0 from that edge. On the next edge with RST=0, DIV_CLK rises and a full 3/3 period follows.
6. N=4, CLK_EN dropped for 5 edges mid-low-phase, then raised -> bypass during the gap, then DIV_CLK=1 and DIV_TICK=1 at the first enabled edge, then a clean 2/2 pattern.
